// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
// RF_BYPASS_EN (optional) enables write-to-read forwarding in regfile_mp.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int DW_DEF       = 32;
    localparam int AW_DEF       = 5;
    localparam int RD_PORTS_MAX = 4;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Background clear sequencer: walks every entry once, then pulses clr_done.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_r;
    rf_state_e     state_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_s;
    logic          last_s;

    assign last_s = (cnt_r == {AW{1'b1}});

    // State and clear-pointer register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RF_IDLE;
            cnt_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the pointer wraps to zero naturally on the last entry
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            RF_IDLE: begin
                if (clr_req) begin
                    state_s = RF_CLEAR;
                    cnt_s   = {AW{1'b0}};
                end else begin
                    state_s = RF_IDLE;
                end
            end
            RF_CLEAR: begin
                cnt_s = cnt_r + AW'(1);
                if (last_s) begin
                    state_s = RF_IDLE;
                end else begin
                    state_s = RF_CLEAR;
                end
            end
            default: begin
                state_s = RF_IDLE;
                cnt_s   = {AW{1'b0}};
            end
        endcase
    end

    assign busy     = (state_r == RF_CLEAR);
    assign clr_done = busy && last_s;
    assign clr_we   = busy;
    assign clr_addr = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: RD_PORTS combinational reads, one write, background clear.
// Define RF_BYPASS_EN to forward the pending write (and pending clear) to the read ports.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int RD_PORTS = 2
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [DW-1:0]          wd,
    output logic                   wr_rdy,
    input  logic [RD_PORTS*AW-1:0] ra,
    output logic [RD_PORTS*DW-1:0] rd,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   clr_done
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic          clr_we_s;
    logic [AW-1:0] clr_addr_s;
    logic          busy_s;
    logic          wr_en_s;

    rf_clear_ctrl #(.AW(AW)) u_clear_ctrl (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_done (clr_done),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    assign busy    = busy_s;
    assign wr_rdy  = !busy_s;
    assign wr_en_s = we && !busy_s && (wa != {AW{1'b0}});

    // Storage array; the clear port only exists while busy, so it takes priority
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (clr_we_s) begin
            mem_r[clr_addr_s] <= {DW{1'b0}};
        end else if (wr_en_s) begin
            mem_r[wa] <= wd;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [AW-1:0] ra_s;
        logic [DW-1:0] rd_s;

        assign ra_s = ra[k*AW +: AW];

        // Read port k; register 0 always reads zero
        always_comb begin
            rd_s = {DW{1'b0}};
            if (ra_s == {AW{1'b0}}) begin
                rd_s = {DW{1'b0}};
            end else begin
                rd_s = mem_r[ra_s];
`ifdef RF_BYPASS_EN
                if (wr_en_s && (ra_s == wa)) begin
                    rd_s = wd;
                end else if (clr_we_s && (ra_s == clr_addr_s)) begin
                    rd_s = {DW{1'b0}};
                end else begin
                    rd_s = mem_r[ra_s];
                end
`endif
            end
        end

        assign rd[k*DW +: DW] = rd_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array model plus directed vectors.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NP    = 2;
    localparam int DEPTH = 32;

    logic           CLK = 1'b0;
    logic           rst_n;
    logic           we;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic           wr_rdy;
    logic [AW-1:0]  ra0, ra1;
    logic [NP*AW-1:0] ra;
    logic [NP*DW-1:0] rd;
    logic           clr_req;
    logic           busy;
    logic           clr_done;

    assign ra = {ra1, ra0};

    regfile_mp #(.DW(DW), .AW(AW), .RD_PORTS(NP)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .wr_rdy   (wr_rdy),
        .ra       (ra),
        .rd       (rd),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_pulses  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the array contents, whether a wipe is running, and which entry it reaches next
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_pos;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we && !m_busy && wa != 0 && a == wa) return wd;
        if (m_busy && int'(a) == m_pos) return '0;
`endif
        return m_mem[a];
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = 0;
        m_pos  = 0;
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                m_busy = 0;
                m_pos  = 0;
            end else if (m_busy) begin
                m_mem[m_pos] = '0;
                if (m_pos == DEPTH - 1) begin
                    m_busy = 0;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end else begin
                if (we && wa != 0) m_mem[wa] = wd;
                if (clr_req) begin
                    m_busy = 1;
                    m_pos  = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model
    initial begin
        forever begin
            @(negedge CLK);
            check("wr_rdy", wr_rdy, !m_busy);
            check("busy", busy, m_busy);
            check("clr_done", clr_done, (m_busy && m_pos == DEPTH - 1));
            check("rd0", rd[DW-1:0], exp_rd(ra0));
            check("rd1", rd[2*DW-1:DW], exp_rd(ra1));
            if (clr_done === 1'b1) done_pulses++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i += 2) begin
            ra0 = AW'(i);
            ra1 = AW'(i + 1);
            #1;
            check(name, rd[DW-1:0], 64'h0);
            check(name, rd[2*DW-1:DW], 64'h0);
            tick();
        end
    endtask

    initial begin
        int bc;
        int d0;
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0; clr_req = 1'b0;

        // 1: reset then reads
        tick(); tick();
        rst_n = 1'b1;
        ra0 = 5'd5; ra1 = 5'd31;
        #1;
        check("t1_rd0", rd[DW-1:0], 64'h0);
        check("t1_rd1", rd[2*DW-1:DW], 64'h0);
        check("t1_wr_rdy", wr_rdy, 64'h1);
        check("t1_busy", busy, 64'h0);
        tick();

        // 2: write/read and register zero
        we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; tick();
        wa = 5'd0; wd = 32'h12345678; tick();
        we = 1'b0; ra0 = 5'd7; ra1 = 5'd0;
        #1;
        check("t2_rd7", rd[DW-1:0], 64'hDEADBEEF);
        check("t2_rd0", rd[2*DW-1:DW], 64'h0);
        tick();

        // 3: same-cycle write/read
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; ra0 = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        check("t3_bypass", rd[DW-1:0], 64'hA5A5A5A5);
`else
        check("t3_nobypass", rd[DW-1:0], 64'h0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("t3_next", rd[DW-1:0], 64'hA5A5A5A5);
        tick();

        // 4: fill with index, then clear
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(i); tick();
        end
        we = 1'b0; ra0 = 5'd15; ra1 = 5'd31;
        #1;
        check("t4_fill15", rd[DW-1:0], 64'd15);
        check("t4_fill31", rd[2*DW-1:DW], 64'd31);
        clr_req = 1'b1; tick();
        clr_req = 1'b0;
        d0 = done_pulses;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            check("t4_wr_rdy", wr_rdy, 64'h0);
            if (bc == 10) begin
                ra0 = 5'd3; ra1 = 5'd20;
                #1;
                check("t4_mid3", rd[DW-1:0], 64'h0);
                check("t4_mid20", rd[2*DW-1:DW], 64'd20);
            end
            if (bc == 31) check("t4_done_last", clr_done, 64'h1);
            bc++;
            tick();
        end
        check("t4_busy_cycles", bc, 64'd32);
        check("t4_done_count", done_pulses - d0, 64'd1);
        read_all_zero("t4_after");

        // 5: simultaneous write+clear, then write during clear is dropped
        we = 1'b1; wa = 5'd4; wd = 32'h77; clr_req = 1'b1; tick();
        clr_req = 1'b0; wd = 32'h55;
        check("t5_busy", busy, 64'h1);
        for (int i = 0; i < 5; i++) tick();
        we = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin bc++; tick(); end
        check("t5_done_wait", bc, 64'd27);
        ra0 = 5'd4;
        #1;
        check("t5_reg4", rd[DW-1:0], 64'h0);
        tick();

        // 6: reset mid-clear
        we = 1'b1; wa = 5'd25; wd = 32'hCAFE; tick();
        we = 1'b0; clr_req = 1'b1; tick();
        clr_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        d0 = done_pulses;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 64'h0);
        check("t6_wr_rdy", wr_rdy, 64'h1);
        check("t6_done", clr_done, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("t6_no_done", done_pulses - d0, 64'd0);
        read_all_zero("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 32x32 three-port register file used by the primitive programmable device.
- Provides configurable data width and address width, RD_PORTS combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Adds a multi-cycle background clear sequence with a busy/done handshake, so software-visible state can be wiped without asserting reset.

Parameters:
DW, 32, data width in bits
AW, 5, address width; DEPTH = 2**AW entries
RD_PORTS, 2, number of read ports (1..4)

Ports:
CLK  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
we  in  1  write enable
wa  in  AW  write address
wd  in  DW  write data
wr_rdy  out  1  high when a write can be accepted this cycle
ra  in  RD_PORTS*AW  read addresses; port k uses bits [k*AW +: AW]
rd  out  RD_PORTS*DW  read data; port k uses bits [k*DW +: DW]
clr_req  in  1  request a full-array clear (level-sampled in IDLE)
busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse on the last clear cycle

Behaviour:
- Reset: asynchronous on rst_n low. Every entry 0..DEPTH-1 becomes 0 (all entries, none skipped). FSM goes to IDLE, clear counter to 0, busy=0, clr_done=0, wr_rdy=1.
- Reads: combinational. rd_k = 0 if ra_k==0, else mem[ra_k]. Read latency is 0 cycles.
- Write: on posedge CLK when we && wr_rdy && wa!=0, mem[wa] <= wd. Writes to address 0 are discarded silently.
- wr_rdy = (state==IDLE). A write presented while wr_rdy=0 is dropped; the producer must hold it until wr_rdy=1.
- FSM states:
  - IDLE -> CLEAR when clr_req=1 at posedge; cnt <= 0.
  - CLEAR: each posedge, mem[cnt] <= 0 and cnt <= cnt+1.
  - When cnt==DEPTH-1 the state returns to IDLE and clr_done=1 for exactly that cycle (combinational on state==CLEAR && cnt==DEPTH-1).
- busy = (state==CLEAR). The clear takes exactly DEPTH cycles. cnt wraps to 0 when leaving CLEAR.
- clr_req during CLEAR is ignored; it does not restart or extend the sequence. clr_req held high through the return to IDLE starts a new clear on the next edge.
- Simultaneous we and clr_req in IDLE: the write commits on that edge and the clear begins on the next cycle, so the written value is later zeroed.
- Reads during CLEAR return current array contents: entries below cnt read 0, the rest keep their old values.
- rst_n asserted mid-clear aborts the sequence immediately. No clr_done pulse is produced.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If we && wr_rdy && wa!=0 && ra_k==wa, then rd_k = wd in the same cycle.
  - During CLEAR, if ra_k==cnt, then rd_k = 0.
- Undefined: no forwarding. Reads show the pre-edge array value; the new value is visible from the next cycle.

Decomposition:
- Package rf_pkg holds:
  - state typedef/constants: RF_IDLE=1'b0, RF_CLEAR=1'b1;
  - default widths DW_DEF=32, AW_DEF=5;
  - RD_PORTS_MAX=4.
- Sub-module rf_clear_ctrl (params AW) is natural. It contains the FSM and counter. Inputs: CLK, rst_n, clr_req. Outputs: busy, clr_done, clr_we, clr_addr.
- The top level holds the storage array, write-port mux (clear has priority since it only exists in CLEAR), read ports and bypass logic.

Test Plan:
1. Reset then reads: rst_n low 2 cycles, release; ra={5,31} -> rd={0,0}, wr_rdy=1, busy=0.
2. Write/read plus zero register: write 0xDEADBEEF to 7, then 0x12345678 to 0; next cycle ra={7,0} -> rd={0xDEADBEEF,0}.
3. Bypass: we=1, wa=9, wd=0xA5A5A5A5, ra0=9 in the same cycle -> rd0=0xA5A5A5A5 with RF_BYPASS_EN; without it, rd0 holds the previous value (0).
4. Clear sequence: fill 1..31 with the value of the index, pulse clr_req.
   - busy high 32 cycles; wr_rdy=0; clr_done pulses once on cycle 32.
   - Mid-clear (cnt=10): ra={3,20} -> {0,20}.
   - Afterwards all entries read 0.
5. Write during clear: we=1, wa=4, wd=0x55 while busy -> dropped; reg 4 reads 0 after clr_done.
6. Reset mid-clear: assert rst_n at cnt=15 -> busy=0 immediately, no clr_done pulse, all entries 0, wr_rdy=1.
